// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the PC, fetches over a req/ack port and issues each
// instruction to decode under a valid/stall handshake, redirecting on branch/jump.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             branch_taken,
    input  logic [15:0]      branch_offset,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    input  logic             stall,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic [CNT_W-1:0] taken_count
);
    localparam logic [1:0]  IDLE  = 2'd0;
    localparam logic [1:0]  REQ   = 2'd1;
    localparam logic [1:0]  ISSUE = 2'd2;
    localparam logic [31:0] RV    = RESET_VECTOR & ~32'h3;
    logic [1:0]  state;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] next_pc;
    logic        advance;
    logic        redirect;
    assign pc_plus4    = pc + 32'd4;
    assign br_target   = pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    assign j_target    = {pc_plus4[31:28], jump_index, 2'b00};
    assign next_pc     = jump ? j_target : branch_taken ? br_target : pc_plus4;
    assign advance     = (state == ISSUE) && !stall;
    assign redirect    = advance && (jump || branch_taken);
    assign imem_req    = state == REQ;
    assign instr_valid = state == ISSUE;
    assign imem_addr   = pc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RV;
            instr <= '0;
        end else if (state == IDLE) begin
            state <= REQ;
        end else if (state == REQ && imem_ack) begin
            instr <= imem_rdata;
            state <= ISSUE;
        end else if (advance) begin
            pc    <= next_pc;
            state <= REQ;
        end
    end
    // Saturating so long runs never alias back to a small count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            taken_count <= '0;
        else if (redirect && !(&taken_count))
            taken_count <= taken_count + CNT_W'(1);
    end
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: directed bench; a narrow counter makes saturation reachable quickly.
module tb_pc_fetch_sequencer;
    localparam int          CW = 4;
    localparam logic [31:0] K  = 32'hA5A5_5A5A;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          branch_taken = 1'b0;
    logic [15:0]   branch_offset = '0;
    logic          jump = 1'b0;
    logic [25:0]   jump_index = '0;
    logic          stall = 1'b0;
    logic          imem_ack = 1'b0;
    logic [31:0]   imem_rdata = '0;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic [31:0]   instr;
    logic          instr_valid;
    logic [31:0]   pc;
    logic [31:0]   pc_plus4;
    logic [CW-1:0] taken_count;
    int n_cmp = 0;
    int n_err = 0;

    pc_fetch_sequencer #(.RESET_VECTOR(32'h0000_0003), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .jump_index(jump_index), .stall(stall), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .imem_req(imem_req), .imem_addr(imem_addr), .instr(instr),
        .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fetch(input logic [31:0] a);
        imem_rdata = a ^ K;
        imem_ack   = 1'b1;
        step();
        imem_ack   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        n_cmp += 5;
        if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 00000000", pc); end
        if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", imem_req); end
        if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        if (instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", instr); end
        if (taken_count !== 4'h0) begin n_err++; $display("FAIL reset_count: got %h want 0", taken_count); end
        rst_n = 1'b1;
        n_cmp++;
        if (imem_req !== 1'b0) begin n_err++; $display("FAIL idle_req: got %b want 0", imem_req); end
        step();
        n_cmp += 2;
        if (imem_req !== 1'b1) begin n_err++; $display("FAIL first_req: got %b want 1", imem_req); end
        if (imem_addr !== 32'h0) begin n_err++; $display("FAIL first_addr: got %h want 0", imem_addr); end
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 4; k++) begin
            logic [31:0] a;
            a = 32'(k * 4);
            fetch(a);
            n_cmp += 4;
            if (instr_valid !== 1'b1) begin n_err++; $display("FAIL seq_valid[%0d]: got %b want 1", k, instr_valid); end
            if (imem_req !== 1'b0) begin n_err++; $display("FAIL seq_req_issue[%0d]: got %b want 0", k, imem_req); end
            if (instr !== (a ^ K)) begin n_err++; $display("FAIL seq_instr[%0d]: got %h want %h", k, instr, a ^ K); end
            if (pc_plus4 !== a + 32'd4) begin n_err++; $display("FAIL seq_pc4[%0d]: got %h want %h", k, pc_plus4, a + 32'd4); end
            step();
            n_cmp += 3;
            if (instr_valid !== 1'b0) begin n_err++; $display("FAIL seq_valid_drop[%0d]: got %b want 0", k, instr_valid); end
            if (imem_req !== 1'b1) begin n_err++; $display("FAIL seq_req[%0d]: got %b want 1", k, imem_req); end
            if (imem_addr !== a + 32'd4) begin n_err++; $display("FAIL seq_addr[%0d]: got %h want %h", k, imem_addr, a + 32'd4); end
        end
    endtask

    task automatic test_branch();
        fetch(32'h10);
        n_cmp++;
        if (pc !== 32'h10) begin n_err++; $display("FAIL br_pc0: got %h want 00000010", pc); end
        branch_taken = 1'b1; branch_offset = 16'h003B;
        step();
        n_cmp += 2;
        if (imem_addr !== 32'h100) begin n_err++; $display("FAIL br_fwd_addr: got %h want 00000100", imem_addr); end
        if (taken_count !== 4'd1) begin n_err++; $display("FAIL br_fwd_count: got %h want 1", taken_count); end
        step();
        n_cmp += 2;
        if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin n_err++; $display("FAIL br_in_req_addr: got %h/%b want 00000100/1", imem_addr, imem_req); end
        if (taken_count !== 4'd1) begin n_err++; $display("FAIL br_in_req_count: got %h want 1", taken_count); end
        fetch(32'h100);
        branch_offset = 16'hFFFE;
        step();
        branch_taken = 1'b0;
        n_cmp += 2;
        if (imem_addr !== 32'hFC) begin n_err++; $display("FAIL br_back_addr: got %h want 000000fc", imem_addr); end
        if (taken_count !== 4'd2) begin n_err++; $display("FAIL br_back_count: got %h want 2", taken_count); end
    endtask

    task automatic test_jump();
        fetch(32'hFC);
        jump = 1'b1; jump_index = 26'h3FF_FFFF;
        step();
        jump = 1'b0;
        n_cmp += 2;
        if (imem_addr !== 32'h0FFF_FFFC) begin n_err++; $display("FAIL jmp_addr: got %h want 0ffffffc", imem_addr); end
        if (taken_count !== 4'd3) begin n_err++; $display("FAIL jmp_count: got %h want 3", taken_count); end
        fetch(32'h0FFF_FFFC);
        step();
        n_cmp += 2;
        if (imem_addr !== 32'h1000_0000) begin n_err++; $display("FAIL seg_cross_addr: got %h want 10000000", imem_addr); end
        if (taken_count !== 4'd3) begin n_err++; $display("FAIL seg_cross_count: got %h want 3", taken_count); end
        fetch(32'h1000_0000);
        n_cmp++;
        if (pc_plus4 !== 32'h1000_0004) begin n_err++; $display("FAIL jmp_pc4: got %h want 10000004", pc_plus4); end
        jump = 1'b1; jump_index = 26'h000_0040; branch_taken = 1'b1; branch_offset = 16'h0100;
        step();
        jump = 1'b0; branch_taken = 1'b0;
        n_cmp += 2;
        if (imem_addr !== 32'h1000_0100) begin n_err++; $display("FAIL jmp_prio_addr: got %h want 10000100", imem_addr); end
        if (taken_count !== 4'd4) begin n_err++; $display("FAIL jmp_prio_count: got %h want 4", taken_count); end
    endtask

    task automatic test_stall();
        fetch(32'h1000_0100);
        stall = 1'b1; branch_taken = 1'b1; branch_offset = 16'h0010;
        imem_rdata = 32'hDEAD_BEEF; imem_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            n_cmp += 4;
            if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin n_err++; $display("FAIL stall_hs[%0d]: got v%b r%b want v1 r0", k, instr_valid, imem_req); end
            if (pc !== 32'h1000_0100) begin n_err++; $display("FAIL stall_pc[%0d]: got %h want 10000100", k, pc); end
            if (instr !== (32'h1000_0100 ^ K)) begin n_err++; $display("FAIL stall_instr[%0d]: got %h want %h", k, instr, 32'h1000_0100 ^ K); end
            if (taken_count !== 4'd4) begin n_err++; $display("FAIL stall_count[%0d]: got %h want 4", k, taken_count); end
        end
        imem_ack = 1'b0; stall = 1'b0;
        step();
        branch_taken = 1'b0;
        n_cmp += 2;
        if (imem_addr !== 32'h1000_0144 || imem_req !== 1'b1) begin n_err++; $display("FAIL stall_release_addr: got %h/%b want 10000144/1", imem_addr, imem_req); end
        if (taken_count !== 4'd5) begin n_err++; $display("FAIL stall_release_count: got %h want 5", taken_count); end
    endtask

    task automatic test_reset_mid_req();
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h1000_0144 || instr_valid !== 1'b0) begin
                n_err++; $display("FAIL wait_ack[%0d]: got r%b a%h v%b want r1 a10000144 v0", k, imem_req, imem_addr, instr_valid);
            end
        end
        rst_n = 1'b0;
        #1;
        n_cmp += 3;
        if (imem_req !== 1'b0) begin n_err++; $display("FAIL async_rst_req: got %b want 0", imem_req); end
        if (pc !== 32'h0) begin n_err++; $display("FAIL async_rst_pc: got %h want 0", pc); end
        if (taken_count !== 4'd0) begin n_err++; $display("FAIL async_rst_count: got %h want 0", taken_count); end
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        step();
        n_cmp++;
        if (instr_valid !== 1'b0 || instr !== 32'h0) begin n_err++; $display("FAIL late_ack_in_rst: got v%b i%h want v0 i0", instr_valid, instr); end
        rst_n = 1'b1;
        step();
        imem_ack = 1'b0;
        n_cmp += 2;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL post_rst_req: got %b/%h want 1/0", imem_req, imem_addr); end
        if (instr_valid !== 1'b0 || instr !== 32'h0) begin n_err++; $display("FAIL late_ack_idle: got v%b i%h want v0 i0", instr_valid, instr); end
    endtask

    task automatic test_wrap_saturate();
        fetch(32'h0);
        branch_taken = 1'b1; branch_offset = 16'hFFFE;
        step();
        branch_taken = 1'b0;
        n_cmp += 2;
        if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL neg_wrap_addr: got %h want fffffffc", imem_addr); end
        if (taken_count !== 4'd1) begin n_err++; $display("FAIL neg_wrap_count: got %h want 1", taken_count); end
        fetch(32'hFFFF_FFFC);
        n_cmp++;
        if (pc_plus4 !== 32'h0) begin n_err++; $display("FAIL wrap_pc4: got %h want 0", pc_plus4); end
        step();
        n_cmp++;
        if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin n_err++; $display("FAIL wrap_addr: got %h/%b want 0/1", imem_addr, imem_req); end
        branch_taken = 1'b1; branch_offset = 16'hFFFF;
        for (int k = 0; k < 14; k++) begin
            fetch(32'h0);
            step();
        end
        n_cmp += 2;
        if (taken_count !== 4'hF) begin n_err++; $display("FAIL count_full: got %h want f", taken_count); end
        if (imem_addr !== 32'h0) begin n_err++; $display("FAIL self_loop_addr: got %h want 0", imem_addr); end
        fetch(32'h0);
        step();
        n_cmp++;
        if (taken_count !== 4'hF) begin n_err++; $display("FAIL count_sat_branch: got %h want f", taken_count); end
        fetch(32'h0);
        jump = 1'b1; jump_index = 26'h0;
        step();
        jump = 1'b0; branch_taken = 1'b0;
        n_cmp += 2;
        if (taken_count !== 4'hF) begin n_err++; $display("FAIL count_sat_jump: got %h want f", taken_count); end
        if (imem_addr !== 32'h0) begin n_err++; $display("FAIL sat_jump_addr: got %h want 0", imem_addr); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stall();
        test_reset_mid_req();
        test_wrap_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
